// File: rtl/nla_pkg.sv
// Shared fixed-point types and helpers for the Horner datapath and its multiplier.
package nla_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;
    localparam int ROUND_HALF = 1 << (FRAC_W_DEF - 1);

    typedef logic signed [DATA_W_DEF-1:0] fxp_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_RUN,
        M_FIN
    } mul_state_t;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] wide,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (wide > hi) return hi;
        if (wide < lo) return lo;
        return wide;
    endfunction

endpackage

// File: rtl/fxp_seq_mul.sv
// Iterative signed fixed-point multiplier: magnitude shift-add, then round, shift and saturate.
// state  | meaning
// M_IDLE | waiting for start; captures operand magnitudes and result sign
// M_RUN  | one shift-add step per cycle, DATA_W steps
// M_FIN  | sign restore, round, shift, saturate, write prod
module fxp_seq_mul
    import nla_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int RND    = ROUND_HALF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic              busy,
    output logic              sat,
    output logic [DATA_W-1:0] prod
);

    localparam int CNT_W = $clog2(DATA_W);

    mul_state_t           state;
    logic [2*DATA_W-1:0]  acc_p;
    logic [2*DATA_W-1:0]  a_sh;
    logic [DATA_W-1:0]    b_sh;
    logic                 sign;
    logic [CNT_W-1:0]     cnt;
    logic signed [63:0]   fin_wide;
    logic signed [63:0]   fin_nar;

    // Magnitude of -2^(DATA_W-1) wraps to itself, which is correct read as unsigned.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        fin_wide = 64'(acc_p);
        if (sign) fin_wide = -fin_wide;
        fin_wide = (fin_wide + 64'(RND)) >>> FRAC_W;
        fin_nar  = sat_narrow(fin_wide, DATA_W);
    end

    assign sat = (state == M_FIN) && (fin_nar != fin_wide);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= M_IDLE;
            acc_p <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            sign  <= 1'b0;
            cnt   <= '0;
            prod  <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else if (clear) begin
            state <= M_IDLE;
            prod  <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                M_IDLE: begin
                    if (start) begin
                        a_sh  <= {{DATA_W{1'b0}}, mag(a)};
                        b_sh  <= mag(b);
                        sign  <= a[DATA_W-1] ^ b[DATA_W-1];
                        acc_p <= '0;
                        cnt   <= CNT_W'(DATA_W - 1);
                        state <= M_RUN;
                        busy  <= 1'b1;
                    end
                end
                M_RUN: begin
                    if (b_sh[0]) acc_p <= acc_p + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    if (cnt == '0) state <= M_FIN;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                M_FIN: begin
                    prod  <= fin_nar[DATA_W-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= M_IDLE;
                end
                default: state <= M_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/horner_datapath.sv
// Horner step datapath: operand capture, acc = sat(acc*x + c), result register, sticky saturation.
module horner_datapath
    import nla_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              dp_reset_i,
    input  logic              rd_signal_i,
    input  logic [DATA_W-1:0] signal_data_i,
    input  logic              rd_coeff_i,
    input  logic [DATA_W-1:0] coeff_data_i,
    input  logic              mul_valid_i,
    output logic              mul_done_o,
    input  logic              add_valid_i,
    output logic              add_done_o,
    input  logic              load_result_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              sat_o,
    output logic              busy_o
);

    logic                 rd_signal_q;
    logic                 rd_coeff_q;
    logic [DATA_W-1:0]    x_q;
    logic [DATA_W-1:0]    c_q;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    prod_q;
    logic                 mul_sat;
    logic signed [DATA_W:0] add_sum;
    logic signed [63:0]   add_nar;
    logic                 add_clamp;

    fxp_seq_mul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .RND    (1 << (FRAC_W - 1))
    ) u_mul (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .clear (dp_reset_i),
        .start (mul_valid_i),
        .a     (acc),
        .b     (x_q),
        .done  (mul_done_o),
        .busy  (busy_o),
        .sat   (mul_sat),
        .prod  (prod_q)
    );

    assign add_sum   = $signed({prod_q[DATA_W-1], prod_q}) + $signed({c_q[DATA_W-1], c_q});
    assign add_nar   = sat_narrow(64'(add_sum), DATA_W);
    assign add_clamp = add_nar != 64'(add_sum);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_signal_q    <= 1'b0;
            rd_coeff_q     <= 1'b0;
            x_q            <= '0;
            c_q            <= '0;
            acc            <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            add_done_o     <= 1'b0;
            sat_o          <= 1'b0;
        end else begin
            // Capture path is independent of dp_reset so in-flight FIFO/ROM reads still land.
            rd_signal_q <= rd_signal_i;
            rd_coeff_q  <= rd_coeff_i;
            if (rd_signal_q) x_q <= signal_data_i;
            if (rd_coeff_q)  c_q <= coeff_data_i;

            if (dp_reset_i) begin
                acc            <= '0;
                sat_o          <= 1'b0;
                add_done_o     <= 1'b0;
                result_valid_o <= 1'b0;
            end else begin
                add_done_o     <= add_valid_i;
                result_valid_o <= load_result_i;
                if (add_valid_i)   acc      <= add_nar[DATA_W-1:0];
                if (load_result_i) result_o <= acc;
                if ((add_valid_i && add_clamp) || mul_sat) sat_o <= 1'b1;
            end
        end
    end

endmodule
